jstep_seq: RTL and testbench

JSTEP_SEQ -- requirements
Module: jstep_seq

---
 rtl/jstep_seq_if.sv | 34 +++
 rtl/jstep_seq.sv | 99 +++++++++
 tb/tb_jstep_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jstep_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : jstep_seq_if
// Brief    : Control and stepper-output bundle for the jstep_seq sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface jstep_seq_if #(
    parameter int NSTEPS = 6,
    parameter int SW     = $clog2(NSTEPS)
);
    logic              mode;
    logic              halt;
    logic              step_req;
    logic [SW-1:0]     last_step;
    logic              wclk;
    logic              wclkd;
    logic              wclke;
    logic              wclks;
    logic [0:NSTEPS-1] bos;
    logic [SW-1:0]     step_idx;
    logic              running;
    logic              cycle_done;

    modport master (
        output mode, halt, step_req, last_step,
        input  wclk, wclkd, wclke, wclks, bos, step_idx, running, cycle_done
    );

    modport slave (
        input  mode, halt, step_req, last_step,
        output wclk, wclkd, wclke, wclks, bos, step_idx, running, cycle_done
    );
endinterface
`default_nettype wire

// File: rtl/jstep_seq.sv
`default_nettype none
// ============================================================================
// Module   : jstep_seq
// Brief    : Four-phase CPU clock generator with one-hot step sequencer,
//            free-run / single-step modes and halt.
// Revision : 1.0 - initial release
// ============================================================================
module jstep_seq #(
    parameter int NSTEPS = 6,
    parameter int SW     = $clog2(NSTEPS)
) (
    input  wire logic   clk,
    input  wire logic   reset,
    jstep_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    localparam logic [SW-1:0] c_MAX_IDX = SW'(NSTEPS - 1);

    phase_t            r_phase;
    logic              r_token;
    logic              r_wclk;
    logic              r_wclkd;
    logic              r_running;
    logic              r_cycle_done;
    logic [SW-1:0]     r_step_idx;
    logic [0:NSTEPS-1] r_bos;

    phase_t            w_phase_next;
    logic              w_start_ok;
    logic              w_consume;
    logic [SW-1:0]     w_eff_last;
    logic [SW-1:0]     w_idx_next;
    logic [0:NSTEPS-1] w_bos_next;

    always_comb begin
        w_start_ok   = !bus.halt && (!bus.mode || r_token);
        // Only a single-step start spends the token; free-run starts leave it pending.
        w_consume    = (r_phase == PH0) && w_start_ok && bus.mode && r_token;
        w_eff_last   = (bus.last_step > c_MAX_IDX) ? c_MAX_IDX : bus.last_step;
        w_idx_next   = (r_step_idx >= w_eff_last) ? '0 : r_step_idx + 1'b1;
        w_bos_next   = '0;
        for (int i = 0; i < NSTEPS; i++) begin
            w_bos_next[i] = (w_idx_next == SW'(i));
        end
        w_phase_next = r_phase;
        case (r_phase)
            PH0:     w_phase_next = w_start_ok ? PH1 : PH0;
            PH1:     w_phase_next = PH2;
            PH2:     w_phase_next = PH3;
            PH3:     w_phase_next = PH0;
            default: w_phase_next = PH0;
        endcase
    end

    // Clock outputs are registered from the next phase so they track r_phase exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase      <= PH0;
            r_token      <= 1'b0;
            r_wclk       <= 1'b1;
            r_wclkd      <= 1'b0;
            r_running    <= 1'b0;
            r_cycle_done <= 1'b0;
            r_step_idx   <= '0;
            r_bos        <= {1'b1, {(NSTEPS-1){1'b0}}};
        end else begin
            r_phase      <= w_phase_next;
            r_wclk       <= (w_phase_next == PH0) || (w_phase_next == PH1);
            r_wclkd      <= (w_phase_next == PH1) || (w_phase_next == PH2);
            r_running    <= (w_phase_next != PH0);
            r_cycle_done <= (r_phase == PH3);
            if (r_phase == PH3) begin
                r_step_idx <= w_idx_next;
                r_bos      <= w_bos_next;
            end
            if (bus.mode && bus.step_req) begin
                r_token <= 1'b1;
            end else if (w_consume) begin
                r_token <= 1'b0;
            end
        end
    end

    assign bus.wclk       = r_wclk;
    assign bus.wclkd      = r_wclkd;
    assign bus.wclke      = r_wclk | r_wclkd;
    assign bus.wclks      = r_wclk & r_wclkd;
    assign bus.bos        = r_bos;
    assign bus.step_idx   = r_step_idx;
    assign bus.running    = r_running;
    assign bus.cycle_done = r_cycle_done;
endmodule
`default_nettype wire

// File: tb/tb_jstep_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_jstep_seq
// Brief    : Scoreboard bench for jstep_seq (NSTEPS=6 and NSTEPS=8 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jstep_seq;
    typedef struct {
        logic [2:0] idx;
        logic [7:0] bos;
    } exp_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    exp_t q6[$];
    exp_t q8[$];

    jstep_seq_if #(.NSTEPS(6)) if6 ();
    jstep_seq_if #(.NSTEPS(8)) if8 ();

    jstep_seq #(.NSTEPS(6)) u6 (.clk(clk), .reset(reset), .bus(if6));
    jstep_seq #(.NSTEPS(8)) u8 (.clk(clk), .reset(reset), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // {wclk, wclkd, wclke, wclks, running}
    task automatic chk_pins(input string nm, input logic [4:0] exp);
        chk(nm, 32'({if6.wclk, if6.wclkd, if6.wclke, if6.wclks, if6.running}), 32'(exp));
    endtask

    task automatic push6(input logic [2:0] idx, input logic [5:0] b);
        q6.push_back('{idx: idx, bos: {2'b00, b}});
    endtask

    // Scoreboard monitors: every cycle_done must match the next queued expectation.
    always @(negedge clk) begin
        if (if6.cycle_done) begin
            if (q6.size() == 0) begin
                n_total++;
                $display("FAIL cyc6_unexpected: got cycle_done idx %0d expected none", if6.step_idx);
            end else begin
                exp_t e;
                e = q6.pop_front();
                chk("cyc6_idx", 32'(if6.step_idx), 32'(e.idx));
                chk("cyc6_bos", 32'(if6.bos), 32'(e.bos));
            end
        end
    end

    always @(negedge clk) begin
        if (if8.cycle_done) begin
            if (q8.size() == 0) begin
                n_total++;
                $display("FAIL cyc8_unexpected: got cycle_done idx %0d expected none", if8.step_idx);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("cyc8_idx", 32'(if8.step_idx), 32'(e.idx));
                chk("cyc8_bos", 32'(if8.bos), 32'(e.bos));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] ph_tab [4];
        logic [7:0] bos8   [9];
        int         cnt;
        bit         done8;
        ph_tab = '{5'b11111, 5'b01101, 5'b00001, 5'b10100};
        bos8   = '{8'b01000000, 8'b00100000, 8'b00010000, 8'b00001000,
                   8'b00000100, 8'b00000010, 8'b00000001, 8'b10000000, 8'b01000000};
        n_pass = 0;
        n_total = 0;
        reset = 1'b0;
        if6.mode = 1'b0; if6.halt = 1'b1; if6.step_req = 1'b0; if6.last_step = 3'd5;
        if8.mode = 1'b0; if8.halt = 1'b1; if8.step_req = 1'b0; if8.last_step = 3'd7;

        @(negedge clk); #1;
        chk_pins("rst_pins", 5'b10100);
        chk("rst_bos", 32'(if6.bos), 32'(6'b100000));
        chk("rst_idx", 32'(if6.step_idx), 0);
        chk("rst_cdone", 32'(if6.cycle_done), 0);

        // Free-run through a full wrap
        @(negedge clk);
        push6(1, 6'b010000); push6(2, 6'b001000); push6(3, 6'b000100);
        push6(4, 6'b000010); push6(5, 6'b000001); push6(0, 6'b100000);
        push6(1, 6'b010000);
        reset = 1'b1; if6.halt = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk_pins("free_phase", ph_tab[k % 4]);
        end
        tick(20);

        // Short wrap, then lowering last_step below the current index
        if6.last_step = 3'd2;
        push6(2, 6'b001000); push6(0, 6'b100000); push6(1, 6'b010000); push6(2, 6'b001000);
        tick(16);
        if6.last_step = 3'd0;
        push6(0, 6'b100000); push6(0, 6'b100000); push6(0, 6'b100000);
        tick(12);

        // Halt raised mid-cycle
        if6.last_step = 3'd5;
        push6(1, 6'b010000);
        tick(2);
        chk_pins("halt_pre_ph2", 5'b01101);
        if6.halt = 1'b1;
        tick(2);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk_pins("halt_parked", 5'b10100);
        end
        push6(2, 6'b001000);
        if6.halt = 1'b0;
        tick(1);
        chk_pins("halt_resume", 5'b11111);
        tick(3);

        // Single-step: two requests while pending give one cycle
        if6.mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk_pins("ss_idle", 5'b10100);
        end
        if6.halt = 1'b1;
        if6.step_req = 1'b1; tick(1);
        if6.step_req = 1'b0; tick(1);
        if6.step_req = 1'b1; tick(1);
        if6.step_req = 1'b0; tick(1);
        push6(3, 6'b000100);
        if6.halt = 1'b0;
        tick(1);
        chk_pins("ss_start", 5'b11111);
        tick(3);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk_pins("ss_parked", 5'b10100);
        end

        // Request arriving as the token is consumed stays pending
        if6.step_req = 1'b1; tick(1);
        tick(1);
        if6.step_req = 1'b0;
        chk("ss_coinc_run", 32'(if6.running), 1);
        push6(4, 6'b000010); push6(5, 6'b000001);
        tick(8);
        for (int k = 0; k < 2; k++) begin
            tick(1);
            chk_pins("ss_coinc_park", 5'b10100);
        end

        // step_req ignored in free-run mode
        if6.mode = 1'b0; if6.halt = 1'b1;
        if6.step_req = 1'b1; tick(1);
        if6.step_req = 1'b0; tick(1);
        if6.mode = 1'b1; if6.halt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk_pins("mode0_req_ignored", 5'b10100);
        end

        // Token survives a free-run interlude
        if6.halt = 1'b1;
        if6.step_req = 1'b1; tick(1);
        if6.step_req = 1'b0;
        push6(0, 6'b100000); push6(1, 6'b010000);
        if6.mode = 1'b0; if6.halt = 1'b0;
        tick(1);
        chk_pins("tok_free_start", 5'b11111);
        tick(1);
        if6.mode = 1'b1;
        tick(2);
        tick(1);
        chk_pins("tok_consumed_start", 5'b11111);
        tick(3);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk_pins("tok_parked", 5'b10100);
        end

        // Reset asserted mid-cycle at index 3
        if6.mode = 1'b0;
        push6(2, 6'b001000); push6(3, 6'b000100);
        tick(8);
        tick(2);
        chk("rstmid_pre_idx", 32'(if6.step_idx), 3);
        chk_pins("rstmid_pre_pins", 5'b01101);
        reset = 1'b0;
        #1;
        chk_pins("rstmid_pins", 5'b10100);
        chk("rstmid_bos", 32'(if6.bos), 32'(6'b100000));
        chk("rstmid_idx", 32'(if6.step_idx), 0);
        chk("rstmid_cdone", 32'(if6.cycle_done), 0);
        if6.halt = 1'b1;
        tick(5);
        reset = 1'b1;
        tick(2);
        chk_pins("rstmid_after", 5'b10100);

        // NSTEPS=8 full walk and wrap
        for (int k = 0; k < 9; k++) begin
            q8.push_back('{idx: 3'((k + 1) % 8), bos: bos8[k]});
        end
        if8.halt = 1'b0;
        cnt = 0;
        done8 = 1'b0;
        for (int k = 0; k < 60 && !done8; k++) begin
            @(negedge clk);
            if (if8.cycle_done) cnt++;
            if (cnt == 9) begin
                if8.halt = 1'b1;
                done8 = 1'b1;
            end
        end
        chk("n8_cycles", 32'(cnt), 9);
        tick(4);
        chk("n8_parked", 32'(if8.running), 0);

        chk("q6_drained", 32'(q6.size()), 0);
        chk("q8_drained", 32'(q8.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
